onchip_mem_loader: RTL
======================

# onchip_mem_loader

Streaming loader that sits directly upstream of the system's 1024 x 32 single-port on-chip memory. It accepts an 8-bit byte stream framed by start/end-of-packet and packs the bytes little-endian into 32-bit words. It writes those words to consecutive memory addresses using the memory's byte-enable port. It can then read the image back and checksum it, so that software or a boot controller knows the load is valid before the processor runs from it.

## Interface
Parameters:
- ADDR_WIDTH, 10, memory word-address width; the memory depth is 2^ADDR_WIDTH words.
- BASE_ADDR, 0, first word address written for each packet.
- VERIFY, 1, when 1 a read-back checksum pass runs after each packet; when 0 it is skipped.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk, in, 1, single clock.
  - reset, in, 1, synchronous, active-high.
- Byte stream input:
  - in_data, in, 8, stream byte.
  - in_valid, in, 1, byte is present.
  - in_ready, out, 1, loader accepts the byte this cycle.
  - in_sop, in, 1, first byte of packet.
  - in_eop, in, 1, last byte of packet.
- Memory side:
  - mem_address, out, ADDR_WIDTH, word address.
  - mem_byteenable, out, 4, lane enables; bit0 = bits 7:0.
  - mem_chipselect, out, 1, memory access this cycle.
  - mem_write, out, 1, write strobe.
  - mem_writedata, out, 32, packed word.
  - mem_readdata, in, 32, read data; valid the cycle after its address is presented.
  - mem_clken, out, 1, memory clock enable.
- Status:
  - busy, out, 1, packet in progress.
  - done, out, 1, one-cycle pulse when a packet completes.
  - overflow, out, 1, bytes were dropped at memory full; sticky until the next SOP.
  - verify_error, out, 1, checksum mismatch; sticky until the next SOP.
  - word_count, out, ADDR_WIDTH+1, words written in the last or current packet.

## Operation
- States: IDLE, LOAD, WRITE, VERIFY, DONE.
- IDLE:
  - in_ready=1.
  - Bytes with in_sop=0 are accepted and discarded.
  - An accepted SOP byte does the following: clears overflow, verify_error, word_count and the write checksum; loads address BASE_ADDR; places the byte in lane 0; and goes to LOAD.
  - If the SOP byte also has in_eop=1, the state goes straight to WRITE.
- LOAD:
  - in_ready=1; each accepted byte fills the next lane, 0 to 3.
  - After lane 3 is filled, or after an accepted EOP byte, the state goes to WRITE.
  - in_sop seen mid-packet is ignored; the byte is treated as data.
- WRITE:
  - in_ready=0.
  - mem_chipselect=1 and mem_write=1 for exactly one cycle.
  - mem_byteenable has a 1 for each filled lane: 4'b1111 for a full word; for a final partial word of k bytes, the low k bits are set.
  - Unfilled lanes of mem_writedata are 0.
  - The write checksum (32-bit modular sum) adds mem_writedata; word_count increments.
  - Then: if the packet has not ended, go to LOAD; if it has ended, go to VERIFY when VERIFY=1, otherwise to DONE.
- Memory full:
  - Once word_count = 2^ADDR_WIDTH - BASE_ADDR, no further writes are issued and the address never wraps.
  - Remaining bytes up to and including EOP are accepted and dropped; overflow=1.
- VERIFY:
  - in_ready=0.
  - mem_chipselect=1, mem_write=0.
  - Addresses BASE_ADDR .. BASE_ADDR+word_count-1 are driven on consecutive cycles.
  - The read data returned one cycle later is masked by the byteenable used when that word was written (only the last word can be partial) and summed.
  - The cycle after the last read data returns, the read sum is compared with the write checksum; verify_error=1 on mismatch.
- DONE: done=1 for one cycle, busy=0, return to IDLE. word_count, overflow and verify_error hold.
- busy=1 in every state except IDLE and DONE.
- mem_clken=1 at all times outside reset.

## Timing
- Reset values:
  - in_ready=0 in the reset cycle, and 1 from the next cycle in IDLE.
  - mem_chipselect=0, mem_write=0, mem_byteenable=0, mem_address=BASE_ADDR, mem_writedata=0, mem_clken=0.
  - busy=0, done=0, overflow=0, verify_error=0, word_count=0.
- All outputs are registered.
- Write latency: the byte completing a word (or the EOP byte) is accepted in cycle t; mem_write=1 in cycle t+1.
- Full-word throughput: 4 bytes per 5 cycles.
- Verify, N words: address phase in cycles 1..N, comparison in cycle N+1, done in cycle N+2.
- An empty-payload case cannot occur, because the SOP byte always carries data.
- Reset mid-operation: abort within the reset cycle. The partial word is discarded, no write is issued afterwards, and the state returns to IDLE.
- in_valid=0 during LOAD stalls with no timeout; the partial word is held.

## Test plan
- Packet 8 bytes 01..08, SOP/EOP framed, BASE_ADDR=0:
  - writes 0x04030201 at address 0 and 0x08070605 at address 1, both with be=1111;
  - word_count=2; done pulses 4 cycles after the last write; verify_error=0.
- Packet 5 bytes AA BB CC DD EE:
  - second write is addr 1, data 0x000000EE, be=0001.
  - Verify masks a readdata value of 0xFFFFFFEE to 0xEE, so there is no error.
- Single byte with SOP and EOP both set (0x5A): one write to addr 0, data 0x5A, be=0001, word_count=1.
- Verify fault injection: the bench returns a flipped bit on the read of addr 1 -> verify_error=1 and done still pulses.
- Overflow: ADDR_WIDTH=2, BASE_ADDR=0, 20-byte packet:
  - exactly 4 writes, to addresses 0..3;
  - the remaining 4 bytes are accepted and dropped; overflow=1; word_count=4.
- Reset asserted one cycle after the 3rd byte of a packet is accepted:
  - no write occurs; all outputs take their reset values;
  - a following packet 11 22 33 44 writes 0x44332211 at addr 0.

Source files
------------

// File: rtl/onchip_mem_loader.sv
// Packs a framed byte stream little-endian into 32-bit words, writes them to on-chip memory, then
// optionally reads the image back and checksums it. A write follows its last byte by one cycle; in_ready drops while memory is busy.
module onchip_mem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0,
  parameter bit VERIFY     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sop,
  input  logic                  in_eop,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [3:0]            mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [31:0]           mem_writedata,
  input  logic [31:0]           mem_readdata,
  output logic                  mem_clken,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  verify_error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]         CAPACITY = CW'((1 << ADDR_WIDTH) - BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_VERIFY,
    S_DONE
  } state_t;

  localparam state_t POST_STATE = VERIFY ? S_VERIFY : S_DONE;

  state_t        state;
  state_t        state_nxt;
  logic [1:0]    lane;
  logic [31:0]   word_buf;
  logic          pkt_end;
  logic [31:0]   wsum;
  logic [31:0]   rsum;
  logic [3:0]    last_be;
  logic [CW-1:0] rd_issued;
  logic          rd_vld;

  logic          accept;
  logic          full;
  logic          word_last;
  logic [31:0]   word_merged;
  logic [3:0]    be_merged;
  logic [31:0]   rd_masked;

  always_comb begin
    accept      = in_valid && in_ready;
    full        = (word_count == CAPACITY);
    word_last   = (lane == 2'd3) || in_eop;
    word_merged = word_buf | ({24'd0, in_data} << {lane, 3'b000});
    case (lane)
      2'd0:    be_merged = 4'b0001;
      2'd1:    be_merged = 4'b0011;
      2'd2:    be_merged = 4'b0111;
      default: be_merged = 4'b1111;
    endcase
    rd_masked = mem_readdata & {{8{last_be[3]}}, {8{last_be[2]}}, {8{last_be[1]}}, {8{last_be[0]}}};

    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept && in_sop) state_nxt = in_eop ? S_WRITE : S_LOAD;
      end
      S_LOAD: begin
        if (accept) begin
          // Once memory is full the rest of the packet is swallowed up to EOP.
          if (full) begin
            if (in_eop) state_nxt = POST_STATE;
          end else if (word_last) begin
            state_nxt = S_WRITE;
          end
        end
      end
      S_WRITE:  state_nxt = pkt_end ? POST_STATE : S_LOAD;
      S_VERIFY: if (!mem_chipselect) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      in_ready       <= 1'b0;
      mem_address    <= BASE;
      mem_byteenable <= 4'b0000;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_writedata  <= 32'd0;
      mem_clken      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      verify_error   <= 1'b0;
      word_count     <= '0;
      lane           <= 2'd0;
      word_buf       <= 32'd0;
      pkt_end        <= 1'b0;
      wsum           <= 32'd0;
      rsum           <= 32'd0;
      last_be        <= 4'b0000;
      rd_issued      <= '0;
      rd_vld         <= 1'b0;
    end else begin
      state          <= state_nxt;
      in_ready       <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
      busy           <= (state_nxt == S_LOAD) || (state_nxt == S_WRITE) || (state_nxt == S_VERIFY);
      done           <= (state_nxt == S_DONE);
      mem_clken      <= 1'b1;
      mem_chipselect <= 1'b0;
      mem_write      <= 1'b0;
      mem_byteenable <= 4'b0000;
      rd_vld         <= (state == S_VERIFY) && mem_chipselect;

      case (state)
        S_IDLE: begin
          if (accept && in_sop) begin
            overflow     <= 1'b0;
            verify_error <= 1'b0;
            word_count   <= '0;
            wsum         <= 32'd0;
            pkt_end      <= in_eop;
            mem_address  <= BASE;
            if (!in_eop) begin
              word_buf <= {24'd0, in_data};
              lane     <= 2'd1;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (full) begin
              overflow <= 1'b1;
            end else begin
              pkt_end <= in_eop;
              if (word_last) begin
                word_buf <= 32'd0;
                lane     <= 2'd0;
              end else begin
                word_buf <= word_merged;
                lane     <= lane + 2'd1;
              end
            end
          end
        end
        S_WRITE: begin
          word_count <= word_count + 1'b1;
          wsum       <= wsum + mem_writedata;
        end
        S_VERIFY: begin
          if (mem_chipselect) begin
            if (rd_vld) rsum <= rsum + mem_readdata;
            if (rd_issued != word_count) begin
              mem_chipselect <= 1'b1;
              mem_byteenable <= 4'b1111;
              mem_address    <= BASE + rd_issued[ADDR_WIDTH-1:0];
              rd_issued      <= rd_issued + 1'b1;
            end
          end else begin
            // Only the final word can be partial, and it is the one returning now.
            verify_error <= (rsum + rd_masked) != wsum;
          end
        end
        default: ;
      endcase

      if (state_nxt == S_WRITE) begin
        mem_chipselect <= 1'b1;
        mem_write      <= 1'b1;
        mem_writedata  <= word_merged;
        mem_byteenable <= be_merged;
        last_be        <= be_merged;
        mem_address    <= (state == S_IDLE) ? BASE : BASE + word_count[ADDR_WIDTH-1:0];
      end

      if ((state_nxt == S_VERIFY) && (state != S_VERIFY)) begin
        mem_chipselect <= 1'b1;
        mem_byteenable <= 4'b1111;
        mem_address    <= BASE;
        rd_issued      <= CW'(1);
        rsum           <= 32'd0;
      end
    end
  end

endmodule
